// File: rtl/control_pipe_pkg.sv
// Shared types and constants for the control-signal pipeline.
// Provides forwarding select codes, control-word field widths, the packed
// per-stage control words and their bubble (NOP) values.
package pipe_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SM_W  = 2;
  localparam int unsigned MM_W  = 2;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  // EX-stage control word: every decode field except the branch bit
  typedef struct packed {
    logic            load_instr;
    logic            rf;
    logic            rw;
    logic            data;
    logic            shift_imm;
    logic [OP_W-1:0] op;
    logic [SM_W-1:0] sm;
    logic [MM_W-1:0] mm;
  } ex_ctrl_t;

  typedef struct packed {
    logic            load_instr;
    logic            rf;
    logic            rw;
    logic [MM_W-1:0] mm;
  } mem_ctrl_t;

  typedef struct packed {
    logic load_instr;
    logic rf;
  } wb_ctrl_t;

  // All-zero words match the decoder's NOP encoding
  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/control_pipe_if.sv
// Decode-side and stage-output bundle of the control pipeline.
// master: decoder/environment side (drives id_*, flush, mem_wait).
// slave : control_pipe side (drives stall, ex_*, mem_*, wb_*, fwd_*).
interface control_pipe_if #(
  parameter int unsigned RW = 4
);
  import pipe_pkg::*;

  logic [OP_W-1:0]  id_op;
  logic [SM_W-1:0]  id_sm;
  logic [MM_W-1:0]  id_mm;
  logic             id_load_instr;
  logic             id_b;
  logic             id_rf;
  logic             id_rw;
  logic             id_data;
  logic             id_shift_imm;
  logic [RW-1:0]    id_rd;
  logic [RW-1:0]    id_rn;
  logic [RW-1:0]    id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic             id_uses_rd;
  logic             flush;
  logic             mem_wait;

  logic             stall;
  logic [OP_W-1:0]  ex_op;
  logic [SM_W-1:0]  ex_sm;
  logic             ex_shift_imm;
  logic [RW-1:0]    ex_rd;
  logic             ex_load_instr;
  logic             ex_rf;
  logic             ex_rw;
  logic             ex_data;
  logic [MM_W-1:0]  ex_mm;
  logic             mem_load_instr;
  logic             mem_rf;
  logic             mem_rw;
  logic [MM_W-1:0]  mem_mm;
  logic [RW-1:0]    mem_rd;
  logic             wb_load_instr;
  logic             wb_rf;
  logic [RW-1:0]    wb_rd;
  logic [FWD_W-1:0] fwd_a;
  logic [FWD_W-1:0] fwd_b;
  logic [FWD_W-1:0] fwd_c;

  modport master (
    output id_op, id_sm, id_mm, id_load_instr, id_b, id_rf, id_rw, id_data,
           id_shift_imm, id_rd, id_rn, id_rm, id_uses_rn, id_uses_rm,
           id_uses_rd, flush, mem_wait,
    input  stall, ex_op, ex_sm, ex_shift_imm, ex_rd, ex_load_instr, ex_rf,
           ex_rw, ex_data, ex_mm, mem_load_instr, mem_rf, mem_rw, mem_mm,
           mem_rd, wb_load_instr, wb_rf, wb_rd, fwd_a, fwd_b, fwd_c
  );

  modport slave (
    input  id_op, id_sm, id_mm, id_load_instr, id_b, id_rf, id_rw, id_data,
           id_shift_imm, id_rd, id_rn, id_rm, id_uses_rn, id_uses_rm,
           id_uses_rd, flush, mem_wait,
    output stall, ex_op, ex_sm, ex_shift_imm, ex_rd, ex_load_instr, ex_rf,
           ex_rw, ex_data, ex_mm, mem_load_instr, mem_rf, mem_rw, mem_mm,
           mem_rd, wb_load_instr, wb_rf, wb_rd, fwd_a, fwd_b, fwd_c
  );

endinterface

// File: rtl/control_pipe_fwd_select.sv
// Operand-forwarding select for one source register.
// Ports: reg_idx/use_reg (consumer), ex/mem/wb producer (rf, rd) pairs,
// sel (2-bit source select, youngest producer wins).
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned RW = 4
) (
  input  logic [RW-1:0]    reg_idx,
  input  logic             use_reg,
  input  logic             ex_rf,
  input  logic [RW-1:0]    ex_rd,
  input  logic             mem_rf,
  input  logic [RW-1:0]    mem_rd,
  input  logic             wb_rf,
  input  logic [RW-1:0]    wb_rd,
  output logic [FWD_W-1:0] sel
);

  // Priority chain EX > MEM > WB > register file
  always_comb begin
    sel = FWD_RF;
    if (use_reg) begin
      if (ex_rf && (ex_rd == reg_idx))        sel = FWD_EX;
      else if (mem_rf && (mem_rd == reg_idx)) sel = FWD_MEM;
      else if (wb_rf && (wb_rd == reg_idx))   sel = FWD_WB;
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubbles,
// branch flush, memory-wait freeze and execute-stage forwarding selects.
// Ports: clk, reset (sync, active-high), bus (control_pipe_if.slave: id_*
// control word, flush, mem_wait in; stall, ex_*/mem_*/wb_*, fwd_a/b/c out).
module control_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  control_pipe_if.slave bus
);

  ex_ctrl_t  ex_q;
  mem_ctrl_t mem_q;
  wb_ctrl_t  wb_q;
  logic [RW-1:0] ex_rd_q;
  logic [RW-1:0] mem_rd_q;
  logic [RW-1:0] wb_rd_q;

  logic     load_use;
  logic     ex_fwd_ok;
  ex_ctrl_t id_word;

  // The branch bit has no consumer past decode
  logic unused_id_b;
  assign unused_id_b = bus.id_b;

  assign id_word = '{load_instr: bus.id_load_instr, rf: bus.id_rf,
                     rw: bus.id_rw, data: bus.id_data,
                     shift_imm: bus.id_shift_imm, op: bus.id_op,
                     sm: bus.id_sm, mm: bus.id_mm};

  // Load in EX whose result the ID instruction needs next cycle
  assign load_use = ex_q.load_instr & ex_q.rf &
                    ((bus.id_uses_rn & (ex_rd_q == bus.id_rn)) |
                     (bus.id_uses_rm & (ex_rd_q == bus.id_rm)) |
                     (bus.id_uses_rd & (ex_rd_q == bus.id_rd)));

  // A flushed ID instruction dies anyway, so it never needs to stall
  assign bus.stall = bus.mem_wait | (load_use & ~bus.flush);

  // Stage registers: reset > mem_wait freeze > bubble insert > advance
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q     <= EX_BUBBLE;
      ex_rd_q  <= '0;
      mem_q    <= MEM_BUBBLE;
      mem_rd_q <= '0;
      wb_q     <= WB_BUBBLE;
      wb_rd_q  <= '0;
    end else if (!bus.mem_wait) begin
      if (bus.flush || load_use) begin
        ex_q    <= EX_BUBBLE;
        ex_rd_q <= '0;
      end else begin
        ex_q    <= id_word;
        ex_rd_q <= bus.id_rd;
      end
      mem_q    <= '{load_instr: ex_q.load_instr, rf: ex_q.rf,
                    rw: ex_q.rw, mm: ex_q.mm};
      mem_rd_q <= ex_rd_q;
      wb_q     <= '{load_instr: mem_q.load_instr, rf: mem_q.rf};
      wb_rd_q  <= mem_rd_q;
    end
  end

  assign bus.ex_op          = ex_q.op;
  assign bus.ex_sm          = ex_q.sm;
  assign bus.ex_shift_imm   = ex_q.shift_imm;
  assign bus.ex_rd          = ex_rd_q;
  assign bus.ex_load_instr  = ex_q.load_instr;
  assign bus.ex_rf          = ex_q.rf;
  assign bus.ex_rw          = ex_q.rw;
  assign bus.ex_data        = ex_q.data;
  assign bus.ex_mm          = ex_q.mm;
  assign bus.mem_load_instr = mem_q.load_instr;
  assign bus.mem_rf         = mem_q.rf;
  assign bus.mem_rw         = mem_q.rw;
  assign bus.mem_mm         = mem_q.mm;
  assign bus.mem_rd         = mem_rd_q;
  assign bus.wb_load_instr  = wb_q.load_instr;
  assign bus.wb_rf          = wb_q.rf;
  assign bus.wb_rd          = wb_rd_q;

  // A load in EX has no data yet; load_use stalls that case instead
  assign ex_fwd_ok = ex_q.rf & ~ex_q.load_instr;

  fwd_select #(.RW(RW)) u_fwd_a (
    .reg_idx(bus.id_rn), .use_reg(bus.id_uses_rn),
    .ex_rf(ex_fwd_ok), .ex_rd(ex_rd_q), .mem_rf(mem_q.rf), .mem_rd(mem_rd_q),
    .wb_rf(wb_q.rf), .wb_rd(wb_rd_q), .sel(bus.fwd_a)
  );

  fwd_select #(.RW(RW)) u_fwd_b (
    .reg_idx(bus.id_rm), .use_reg(bus.id_uses_rm),
    .ex_rf(ex_fwd_ok), .ex_rd(ex_rd_q), .mem_rf(mem_q.rf), .mem_rd(mem_rd_q),
    .wb_rf(wb_q.rf), .wb_rd(wb_rd_q), .sel(bus.fwd_b)
  );

  fwd_select #(.RW(RW)) u_fwd_c (
    .reg_idx(bus.id_rd), .use_reg(bus.id_uses_rd),
    .ex_rf(ex_fwd_ok), .ex_rd(ex_rd_q), .mem_rf(mem_q.rf), .mem_rd(mem_rd_q),
    .wb_rf(wb_q.rf), .wb_rd(wb_rd_q), .sel(bus.fwd_c)
  );

endmodule

// File: tb/tb_control_pipe.sv
// Directed, table-driven bench for control_pipe plus hand sequences for
// mem_wait freeze and reset during a wait.
module tb_control_pipe;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  control_pipe_if #(.RW(4)) bus ();

  control_pipe #(.RW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] op;
    logic       ld;
    logic       rf;
    logic [3:0] rd;
    logic [3:0] rn;
    logic [3:0] rm;
    logic       urn;
    logic       urm;
    logic       urd;
    logic       fl;
    logic       x_stall;
    logic [1:0] x_fa;
    logic [1:0] x_fb;
    logic [1:0] x_fc;
    logic [3:0] x_ex_op;
    logic [3:0] x_ex_rd;
    logic       x_ex_ld;
    logic [3:0] x_mem_rd;
    logic [3:0] x_wb_rd;
    logic       x_wb_rf;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic clear_inputs();
    bus.id_op = '0; bus.id_sm = '0; bus.id_mm = '0;
    bus.id_load_instr = 1'b0; bus.id_b = 1'b0; bus.id_rf = 1'b0;
    bus.id_rw = 1'b0; bus.id_data = 1'b0; bus.id_shift_imm = 1'b0;
    bus.id_rd = '0; bus.id_rn = '0; bus.id_rm = '0;
    bus.id_uses_rn = 1'b0; bus.id_uses_rm = 1'b0; bus.id_uses_rd = 1'b0;
    bus.flush = 1'b0; bus.mem_wait = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          op ld rf rd rn rm urn urm urd fl | st fa fb fc | eop erd eld mrd wrd wrf
    vecs[0]  = '{4, 0, 1, 3, 1, 2, 1, 1, 0, 0,  0, 0, 0, 0,  4, 3, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 3, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 3, 1};
    vecs[3]  = '{4, 1, 1, 2, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0,  4, 2, 1, 0, 0, 0};
    vecs[4]  = '{4, 0, 1, 4, 2, 1, 1, 1, 0, 0,  1, 0, 0, 0,  0, 0, 0, 2, 0, 0};
    vecs[5]  = '{4, 0, 1, 4, 2, 1, 1, 1, 0, 0,  0, 2, 0, 0,  4, 4, 0, 0, 2, 1};
    vecs[6]  = '{4, 0, 1, 5, 4, 2, 1, 1, 0, 0,  0, 1, 3, 0,  4, 5, 0, 4, 0, 0};
    vecs[7]  = '{2, 0, 1, 5, 3, 4, 1, 1, 0, 0,  0, 0, 2, 0,  2, 5, 0, 5, 4, 1};
    vecs[8]  = '{0, 0, 0, 0, 5, 5, 1, 0, 0, 0,  0, 1, 0, 0,  0, 0, 0, 5, 5, 1};
    vecs[9]  = '{0, 0, 0, 0, 5, 5, 1, 1, 0, 0,  0, 2, 2, 0,  0, 0, 0, 0, 5, 1};
    vecs[10] = '{0, 0, 0, 0, 5, 5, 1, 1, 0, 0,  0, 3, 3, 0,  0, 0, 0, 0, 0, 0};
    vecs[11] = '{4, 1, 1, 6, 1, 0, 1, 0, 0, 0,  0, 0, 0, 0,  4, 6, 1, 0, 0, 0};
    vecs[12] = '{4, 0, 1, 7, 6, 0, 1, 0, 0, 1,  0, 0, 0, 0,  0, 0, 0, 6, 0, 0};
    vecs[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 6, 1};
    vecs[14] = '{0, 0, 0, 6, 0, 0, 0, 0, 1, 0,  0, 0, 0, 3,  0, 6, 0, 0, 0, 0};

    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;

    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_fwd_a", 32'(bus.fwd_a), 0);
    chk("rst_fwd_b", 32'(bus.fwd_b), 0);
    chk("rst_fwd_c", 32'(bus.fwd_c), 0);
    chk("rst_ex_op", 32'(bus.ex_op), 0);
    chk("rst_ex_rf", 32'(bus.ex_rf), 0);
    chk("rst_mem_rf", 32'(bus.mem_rf), 0);
    chk("rst_wb_rf", 32'(bus.wb_rf), 0);

    for (int i = 0; i < NV; i++) begin
      bus.id_op = vecs[i].op;
      bus.id_load_instr = vecs[i].ld;
      bus.id_rf = vecs[i].rf;
      bus.id_rd = vecs[i].rd;
      bus.id_rn = vecs[i].rn;
      bus.id_rm = vecs[i].rm;
      bus.id_uses_rn = vecs[i].urn;
      bus.id_uses_rm = vecs[i].urm;
      bus.id_uses_rd = vecs[i].urd;
      bus.flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d_fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].x_fa));
      chk($sformatf("v%0d_fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].x_fb));
      chk($sformatf("v%0d_fwd_c", i), 32'(bus.fwd_c), 32'(vecs[i].x_fc));
      step();
      chk($sformatf("v%0d_ex_op", i), 32'(bus.ex_op), 32'(vecs[i].x_ex_op));
      chk($sformatf("v%0d_ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].x_ex_rd));
      chk($sformatf("v%0d_ex_ld", i), 32'(bus.ex_load_instr), 32'(vecs[i].x_ex_ld));
      chk($sformatf("v%0d_mem_rd", i), 32'(bus.mem_rd), 32'(vecs[i].x_mem_rd));
      chk($sformatf("v%0d_wb_rd", i), 32'(bus.wb_rd), 32'(vecs[i].x_wb_rd));
      chk($sformatf("v%0d_wb_rf", i), 32'(bus.wb_rf), 32'(vecs[i].x_wb_rf));
    end

    // Full-width control word into EX
    clear_inputs();
    bus.id_op = 4'd9; bus.id_sm = 2'd2; bus.id_mm = 2'd1; bus.id_rw = 1'b1;
    bus.id_data = 1'b1; bus.id_shift_imm = 1'b1; bus.id_b = 1'b1;
    bus.id_rf = 1'b1; bus.id_rd = 4'd8;
    step();
    chk("w_ex_op", 32'(bus.ex_op), 9);
    chk("w_ex_sm", 32'(bus.ex_sm), 2);
    chk("w_ex_mm", 32'(bus.ex_mm), 1);
    chk("w_ex_rw", 32'(bus.ex_rw), 1);
    chk("w_ex_data", 32'(bus.ex_data), 1);
    chk("w_ex_shift_imm", 32'(bus.ex_shift_imm), 1);
    chk("w_ex_rf", 32'(bus.ex_rf), 1);
    chk("w_ex_rd", 32'(bus.ex_rd), 8);
    chk("w_mem_rd", 32'(bus.mem_rd), 6);

    // mem_wait for three cycles with a consumer of r8 in ID
    clear_inputs();
    bus.id_op = 4'd1; bus.id_rf = 1'b1; bus.id_rd = 4'd9;
    bus.id_rn = 4'd8; bus.id_uses_rn = 1'b1;
    bus.mem_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw%0d_stall", c), 32'(bus.stall), 1);
      chk($sformatf("mw%0d_fwd_a", c), 32'(bus.fwd_a), 1);
      step();
      chk($sformatf("mw%0d_ex_op", c), 32'(bus.ex_op), 9);
      chk($sformatf("mw%0d_ex_rd", c), 32'(bus.ex_rd), 8);
      chk($sformatf("mw%0d_mem_rd", c), 32'(bus.mem_rd), 6);
      chk($sformatf("mw%0d_wb_rd", c), 32'(bus.wb_rd), 0);
    end
    bus.mem_wait = 1'b0;
    #1;
    chk("mw_rel_stall", 32'(bus.stall), 0);
    chk("mw_rel_fwd_a", 32'(bus.fwd_a), 1);
    step();
    chk("mw_rel_ex_op", 32'(bus.ex_op), 1);
    chk("mw_rel_ex_rd", 32'(bus.ex_rd), 9);
    chk("mw_rel_mem_rd", 32'(bus.mem_rd), 8);
    chk("mw_rel_mem_rw", 32'(bus.mem_rw), 1);
    chk("mw_rel_mem_mm", 32'(bus.mem_mm), 1);
    chk("mw_rel_mem_rf", 32'(bus.mem_rf), 1);
    chk("mw_rel_wb_rd", 32'(bus.wb_rd), 6);

    // Reset during mem_wait and flush with a populated pipeline
    bus.id_op = 4'd4; bus.id_load_instr = 1'b1; bus.id_rd = 4'd9;
    bus.mem_wait = 1'b1; bus.flush = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_inputs();
    #1;
    chk("rw_stall", 32'(bus.stall), 0);
    chk("rw_ex_op", 32'(bus.ex_op), 0);
    chk("rw_ex_rd", 32'(bus.ex_rd), 0);
    chk("rw_ex_rf", 32'(bus.ex_rf), 0);
    chk("rw_ex_rw", 32'(bus.ex_rw), 0);
    chk("rw_ex_mm", 32'(bus.ex_mm), 0);
    chk("rw_mem_rd", 32'(bus.mem_rd), 0);
    chk("rw_mem_rf", 32'(bus.mem_rf), 0);
    chk("rw_mem_rw", 32'(bus.mem_rw), 0);
    chk("rw_wb_rd", 32'(bus.wb_rd), 0);
    chk("rw_wb_rf", 32'(bus.wb_rf), 0);
    chk("rw_wb_ld", 32'(bus.wb_load_instr), 0);
    chk("rw_fwd_a", 32'(bus.fwd_a), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
# control_pipe

Control-signal pipeline from decode through write-back: captures the decoder's per-instruction control word each cycle and carries it through the ID/EX, EX/MEM and MEM/WB registers. It also:
- detects load-use hazards and inserts bubbles;
- applies branch flushes;
- freezes on memory wait;
- produces operand-forwarding selects for the execute-stage operand muxes.

It sits directly downstream of the instruction decoder/control unit and upstream of the ALU, data memory and register-file write port.

## Interface
Parameters:
- RW, 4, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_op  in  4  ALU opcode from decode.
- id_sm  in  2  shifter mode.
- id_mm  in  2  memory access size.
- id_load_instr, id_b, id_rf, id_rw, id_data, id_shift_imm  in  1 each  decode control bits.
- id_rd, id_rn, id_rm  in  RW  register fields of the ID instruction.
- id_uses_rn, id_uses_rm, id_uses_rd  in  1 each  ID instruction reads that field; id_uses_rd is set for stores.
- flush  in  1  branch taken; kill the instruction currently in ID.
- mem_wait  in  1  data memory not ready.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_op  out  4;  ex_sm  out  2;  ex_shift_imm  out  1;  ex_rd  out  RW  EX-stage controls.
- ex_load_instr, ex_rf, ex_rw, ex_data  out  1 each;  ex_mm  out  2.
- mem_load_instr, mem_rf, mem_rw  out  1 each;  mem_mm  out  2;  mem_rd  out  RW.
- wb_load_instr, wb_rf  out  1 each;  wb_rd  out  RW.
- fwd_a, fwd_b, fwd_c  out  2 each  operand source select for Rn, Rm and store-data Rd.

## Operation
- A bubble is an all-zero control word, which matches the decoder's NOP encoding.
- Control-word fields per stage:
  - EX: all decode fields except id_b.
  - MEM: load_instr, rf, rw, mm, rd.
  - WB: load_instr, rf, rd.
- load_use = ex_load_instr & ex_rf & ((id_uses_rn & ex_rd==id_rn) | (id_uses_rm & ex_rd==id_rm) | (id_uses_rd & ex_rd==id_rd)).
- Per-cycle update priority:
  1. reset: all stage registers cleared.
  2. mem_wait: all three stage registers hold.
  3. flush: ID/EX captures a bubble; EX/MEM and MEM/WB advance.
  4. load_use: ID/EX captures a bubble; EX/MEM and MEM/WB advance.
  5. Otherwise: ID/EX captures the id_* word; all stages advance.
- stall = mem_wait | (load_use & ~flush). flush takes precedence over load_use because the ID instruction dies anyway.
- Forwarding select, computed for each of rn→fwd_a, rm→fwd_b, rd→fwd_c:
  - 01 if ex_rf & ~ex_load_instr & ex_rd==reg;
  - else 10 if mem_rf & mem_rd==reg;
  - else 11 if wb_rf & wb_rd==reg;
  - else 00 (register file).
  - The youngest producer wins.
  - An EX-stage load never forwards from EX; load_use covers that case.
- Forward selects are 00 whenever the corresponding id_uses_* is 0.

## Timing
- Reset value of every registered output is 0, so fwd_* = 00 and stall = 0 out of reset, given inputs low.
- Latency: the ID word appears on ex_* one cycle after capture, on mem_* after two, on wb_* after three, absent stalls.
- stall, load_use and fwd_* are combinational from current stage registers and id_* inputs; no added latency.
- A load-use stall lasts exactly one cycle: the next cycle the load is in MEM and fwd selects 10.
- mem_wait held for N cycles freezes all stages for N cycles. stall stays high for the whole wait, and fwd_* stay stable.
- reset asserted mid-operation clears all stages at the next edge, regardless of mem_wait or flush.

## Structure
- Shared package `pipe_pkg`:
  - forwarding codes FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11;
  - the control-word field widths;
  - the bubble constant.
- One sub-module, `fwd_select`: takes the register index, its use flag and the three producer (rf, rd) pairs, and returns the 2-bit select. It is instantiated three times.

## Test plan
- Reset, then drive ADD (id_op=0100, id_rf=1, id_rd=3) → ex_op=0100 and ex_rd=3 after 1 cycle; mem_rd=3 after 2; wb_rf=1, wb_rd=3 after 3.
- LDR r2 followed by ADD using rn=2:
  - stall=1 for one cycle and EX holds a bubble;
  - the next cycle fwd_a=10 and stall=0.
- Back-to-back ALU writes to r5 (EX) and r5 (MEM), consumer rn=5 → fwd_a=01. Remove the EX producer → 10; leave only the WB producer → 11.
- flush=1 together with a load-use condition → stall=0, ex_* all zero next cycle, MEM/WB advance.
- mem_wait=1 for 3 cycles mid-stream → all stage outputs unchanged, stall=1 throughout; the pipeline resumes the cycle after release.
- reset asserted during mem_wait with a populated pipeline → every output 0 after the next edge.
